// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its
// behavioural instruction memory.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ISSUE,
    FAULT
  } state_t;

  localparam int          WORD_BYTES       = 4;
  localparam int          INS_W            = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'(WORD_BYTES);
  endfunction

endpackage

// File: rtl/instr_mem_model.sv
// Behavioural multi-cycle word memory for the instruction fetch unit.
// A read held high stalls for LAT cycles, then presents the word with
// busywait low. Preloaded one word per cycle through the load port.
module instr_mem_model
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LAT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-3:0] load_addr,
  input  logic [INS_W-1:0]  load_data,
  input  logic              read,
  input  logic [ADDR_W-1:0] address,
  output logic [INS_W-1:0]  readdata,
  output logic              busywait
);

  localparam int             WORDS   = 2 ** (ADDR_W - 2);
  localparam int             CNT_W   = $clog2(LAT + 2);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

  logic [INS_W-1:0] mem [WORDS];
  logic [CNT_W-1:0] cnt;
  logic             unused_byte_offset;

  assign busywait           = read && (cnt != LAT_CNT);
  assign readdata           = mem[address[ADDR_W-1:2]];
  assign unused_byte_offset = ^address[1:0];

  // Latency counter: counts busy cycles of an outstanding read, clears otherwise.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) cnt <= '0;
    else       cnt <= busywait ? cnt + 1'b1 : '0;
  end

  // Preload write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; contents come from the load port.
    if (load_en) mem[load_addr] <= load_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from a
// multi-cycle memory and presents it to the cpu until released.
// Optional build macro ALIGN_CHECK_EN: a taken branch to a non-word-aligned
// target traps in FAULT (FETCH_FAULT=1) instead of being word-aligned.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              BRANCH_TAKEN,
  input  logic [31:0]       BRANCH_TARGET,
  input  logic [INS_W-1:0]  MEM_READDATA,
  input  logic              MEM_BUSYWAIT,
  output logic              MEM_READ,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [31:0]       PC,
  output logic [INS_W-1:0]  INSTRUCTION,
  output logic              INS_VALID,
  output logic              BUSYWAIT,
  output logic              FETCH_FAULT
);

  state_t           state;
  logic [31:0]      pc_q;
  logic [INS_W-1:0] instruction_q;
  logic             ins_valid_q;
  logic             mem_read_q;
  logic             fault_q;

  logic [31:0]      next_pc;
  logic             take_fault;

  // Release-time decisions: successor PC and whether the branch traps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    take_fault = 1'b0;
`ifdef ALIGN_CHECK_EN
    take_fault = BRANCH_TAKEN && (BRANCH_TARGET[1:0] != 2'b00);
    next_pc    = BRANCH_TAKEN ? BRANCH_TARGET : next_seq_pc(pc_q);
`else
    next_pc    = BRANCH_TAKEN ? (BRANCH_TARGET & ~32'(WORD_BYTES - 1))
                              : next_seq_pc(pc_q);
`endif
  end

  // Fetch sequencer with registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      pc_q          <= RESET_PC;
      instruction_q <= '0;
      ins_valid_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_read_q <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (!MEM_BUSYWAIT) begin
            instruction_q <= MEM_READDATA;
            ins_valid_q   <= 1'b1;
            mem_read_q    <= 1'b0;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (!STALL) begin
            ins_valid_q <= 1'b0;
            if (take_fault) begin
              pc_q    <= BRANCH_TARGET;
              fault_q <= 1'b1;
              state   <= FAULT;
            end else begin
              pc_q       <= next_pc;
              mem_read_q <= 1'b1;
              state      <= WAIT;
            end
          end
        end
        FAULT: begin
          ins_valid_q <= 1'b0;
          mem_read_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign PC          = pc_q;
  assign MEM_ADDRESS = pc_q[ADDR_W-1:0];
  assign MEM_READ    = mem_read_q;
  assign INSTRUCTION = instruction_q;
  assign INS_VALID   = ins_valid_q;
  assign BUSYWAIT    = ~ins_valid_q;
`ifdef ALIGN_CHECK_EN
  assign FETCH_FAULT = fault_q;
`else
  assign FETCH_FAULT = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with instr_mem_model (LAT=4).
// Build with or without ALIGN_CHECK_EN; the alignment test follows the macro.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int ADDR_W       = 10;
  localparam int LAT          = 4;
  localparam int WORDS        = 2 ** (ADDR_W - 2);
  localparam int FETCH_CYCLES = LAT + 2;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              STALL;
  logic              BRANCH_TAKEN;
  logic [31:0]       BRANCH_TARGET;
  logic [31:0]       MEM_READDATA;
  logic              MEM_BUSYWAIT;
  logic              MEM_READ;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [31:0]       PC;
  logic [31:0]       INSTRUCTION;
  logic              INS_VALID;
  logic              BUSYWAIT;
  logic              FETCH_FAULT;

  logic              load_en;
  logic [ADDR_W-3:0] load_addr;
  logic [31:0]       load_data;

  int errors = 0;
  int checks = 0;
  logic [31:0] image [WORDS];

  always #5 CLK = ~CLK;

  instruction_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .RESET(RESET), .STALL(STALL), .BRANCH_TAKEN(BRANCH_TAKEN),
    .BRANCH_TARGET(BRANCH_TARGET), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
    .PC(PC), .INSTRUCTION(INSTRUCTION), .INS_VALID(INS_VALID),
    .BUSYWAIT(BUSYWAIT), .FETCH_FAULT(FETCH_FAULT)
  );

  instr_mem_model #(.ADDR_W(ADDR_W), .LAT(LAT)) mem (
    .clk(CLK), .reset(RESET), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .read(MEM_READ), .address(MEM_ADDRESS),
    .readdata(MEM_READDATA), .busywait(MEM_BUSYWAIT)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = idx[ADDR_W-3:0];
    load_data = data;
    step();
    load_en   = 1'b0;
    image[idx] = data;
  endtask

  task automatic do_reset();
    RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    step();
    step();
  endtask

  // Steps until INS_VALID; the first edge uses caller-set inputs, later edges
  // optionally see random STALL/BRANCH noise that the DUT must ignore in WAIT.
  task automatic wait_valid(output int n, output bit timed_out, input bit junk);
    n = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (INS_VALID) begin
        timed_out = 1'b0;
        break;
      end
      if (junk) begin
        STALL         = 1'($urandom_range(0, 1));
        BRANCH_TAKEN  = 1'($urandom_range(0, 1));
        BRANCH_TARGET = $urandom;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (PC !== 32'h0 || INSTRUCTION !== 32'h0 || INS_VALID !== 1'b0 ||
        MEM_READ !== 1'b0 || FETCH_FAULT !== 1'b0 || BUSYWAIT !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got pc=%h ins=%h v=%b rd=%b ff=%b bw=%b expected pc=0 ins=0 v=0 rd=0 ff=0 bw=1",
               PC, INSTRUCTION, INS_VALID, MEM_READ, FETCH_FAULT, BUSYWAIT);
    end
  endtask

  task automatic test_first_fetch();
    bit low_ok;
    RESET = 1'b1;
    load_word(0, 32'hFF03_0201);
    do_reset();
    RESET = 1'b0;
    step();
    checks++;
    if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 10'h0 || INS_VALID !== 1'b0) begin
      errors++;
      $display("FAIL first_read_edge1: got rd=%b addr=%h v=%b expected rd=1 addr=0 v=0",
               MEM_READ, MEM_ADDRESS, INS_VALID);
    end
    low_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (INS_VALID !== 1'b0 || MEM_READ !== 1'b1) low_ok = 1'b0;
    end
    checks++;
    if (!low_ok) begin
      errors++;
      $display("FAIL first_wait_edges2to5: got early valid or dropped read expected v=0 rd=1");
    end
    step();
    checks++;
    if (INS_VALID !== 1'b1 || INSTRUCTION !== 32'hFF03_0201 || PC !== 32'h0 || MEM_READ !== 1'b0) begin
      errors++;
      $display("FAIL first_valid_edge6: got v=%b ins=%h pc=%h rd=%b expected v=1 ins=ff030201 pc=0 rd=0",
               INS_VALID, INSTRUCTION, PC, MEM_READ);
    end
    step();
    checks++;
    if (PC !== 32'h4 || INS_VALID !== 1'b0 || MEM_READ !== 1'b1) begin
      errors++;
      $display("FAIL first_release_edge7: got pc=%h v=%b rd=%b expected pc=4 v=0 rd=1",
               PC, INS_VALID, MEM_READ);
    end
  endtask

  task automatic test_sequence();
    int n;
    bit to;
    RESET = 1'b1;
    for (int k = 0; k < 4; k++) load_word(k, 32'h11 * (k + 1));
    do_reset();
    RESET = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(n, to, 1'b0);
      checks++;
      if (to || n != FETCH_CYCLES || INSTRUCTION !== 32'h11 * (k + 1) || PC !== 32'(4 * k)) begin
        errors++;
        $display("FAIL seq_fetch%0d: got timeout=%b cycles=%0d ins=%h pc=%h expected cycles=%0d ins=%h pc=%h",
                 k, to, n, INSTRUCTION, PC, FETCH_CYCLES, 32'h11 * (k + 1), 32'(4 * k));
      end
    end
  endtask

  task automatic test_stall();
    int n;
    bit to;
    bit hold_ok;
    do_reset();
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) wait_valid(n, to, 1'b0);
    checks++;
    if (to || PC !== 32'h8) begin
      errors++;
      $display("FAIL stall_reach_pc8: got timeout=%b pc=%h expected pc=8", to, PC);
    end
    STALL = 1'b1;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      BRANCH_TAKEN  = 1'($urandom_range(0, 1));
      BRANCH_TARGET = 32'h80;
      step();
      if (PC !== 32'h8 || INSTRUCTION !== 32'h33 || MEM_READ !== 1'b0 || INS_VALID !== 1'b1)
        hold_ok = 1'b0;
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL stall_hold: got pc=%h ins=%h rd=%b v=%b expected pc=8 ins=33 rd=0 v=1",
               PC, INSTRUCTION, MEM_READ, INS_VALID);
    end
    STALL = 1'b0;
    BRANCH_TAKEN = 1'b0;
    step();
    checks++;
    if (PC !== 32'hC || MEM_READ !== 1'b1 || INS_VALID !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got pc=%h rd=%b v=%b expected pc=c rd=1 v=0", PC, MEM_READ, INS_VALID);
    end
    wait_valid(n, to, 1'b0);
    checks++;
    if (to || n != FETCH_CYCLES - 1 || INSTRUCTION !== 32'h44) begin
      errors++;
      $display("FAIL stall_next_fetch: got timeout=%b cycles=%0d ins=%h expected cycles=%0d ins=44",
               to, n, INSTRUCTION, FETCH_CYCLES - 1);
    end
  endtask

  task automatic test_branch();
    int n;
    bit to;
    RESET = 1'b1;
    load_word(16, 32'hA0A0_0040);
    do_reset();
    RESET = 1'b0;
    wait_valid(n, to, 1'b0);
    wait_valid(n, to, 1'b0);
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'h40;
    step();
    checks++;
    if (PC !== 32'h40 || MEM_ADDRESS !== 10'h40 || MEM_READ !== 1'b1) begin
      errors++;
      $display("FAIL branch_taken: got pc=%h addr=%h rd=%b expected pc=40 addr=40 rd=1",
               PC, MEM_ADDRESS, MEM_READ);
    end
    BRANCH_TARGET = 32'h100;
    step();
    step();
    BRANCH_TAKEN = 1'b0;
    wait_valid(n, to, 1'b0);
    checks++;
    if (to || n != FETCH_CYCLES - 3 || PC !== 32'h40 || INSTRUCTION !== 32'hA0A0_0040) begin
      errors++;
      $display("FAIL branch_in_wait_ignored: got timeout=%b cycles=%0d pc=%h ins=%h expected cycles=%0d pc=40 ins=a0a00040",
               to, n, PC, INSTRUCTION, FETCH_CYCLES - 3);
    end
    step();
    checks++;
    if (PC !== 32'h44) begin
      errors++;
      $display("FAIL branch_then_seq: got pc=%h expected pc=44", PC);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    bit to;
    do_reset();
    RESET = 1'b0;
    wait_valid(n, to, 1'b0);
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'h40;
    step();
    BRANCH_TAKEN = 1'b0;
    step();
    step();
    RESET = 1'b1;
    step();
    checks++;
    if (PC !== 32'h0 || MEM_READ !== 1'b0 || INS_VALID !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: got pc=%h rd=%b v=%b expected pc=0 rd=0 v=0", PC, MEM_READ, INS_VALID);
    end
    RESET = 1'b0;
    wait_valid(n, to, 1'b0);
    checks++;
    if (to || n != FETCH_CYCLES || PC !== 32'h0 || INSTRUCTION !== image[0]) begin
      errors++;
      $display("FAIL restart_after_reset: got timeout=%b cycles=%0d pc=%h ins=%h expected cycles=%0d pc=0 ins=%h",
               to, n, PC, INSTRUCTION, FETCH_CYCLES, image[0]);
    end
  endtask

  task automatic test_alignment();
    int n;
    bit to;
    do_reset();
    RESET = 1'b0;
    wait_valid(n, to, 1'b0);
    BRANCH_TAKEN  = 1'b1;
    BRANCH_TARGET = 32'h42;
    step();
    BRANCH_TAKEN = 1'b0;
`ifdef ALIGN_CHECK_EN
    checks++;
    if (FETCH_FAULT !== 1'b1 || MEM_READ !== 1'b0 || INS_VALID !== 1'b0 || PC !== 32'h42) begin
      errors++;
      $display("FAIL align_fault_entry: got ff=%b rd=%b v=%b pc=%h expected ff=1 rd=0 v=0 pc=42",
               FETCH_FAULT, MEM_READ, INS_VALID, PC);
    end
    for (int i = 0; i < 8; i++) begin
      BRANCH_TAKEN  = 1'($urandom_range(0, 1));
      BRANCH_TARGET = $urandom;
      STALL         = 1'($urandom_range(0, 1));
      step();
    end
    checks++;
    if (FETCH_FAULT !== 1'b1 || MEM_READ !== 1'b0 || INS_VALID !== 1'b0 || PC !== 32'h42) begin
      errors++;
      $display("FAIL align_fault_sticky: got ff=%b rd=%b v=%b pc=%h expected ff=1 rd=0 v=0 pc=42",
               FETCH_FAULT, MEM_READ, INS_VALID, PC);
    end
`else
    checks++;
    if (PC !== 32'h40 || MEM_ADDRESS !== 10'h40 || FETCH_FAULT !== 1'b0 || MEM_READ !== 1'b1) begin
      errors++;
      $display("FAIL align_forced: got pc=%h addr=%h ff=%b rd=%b expected pc=40 addr=40 ff=0 rd=1",
               PC, MEM_ADDRESS, FETCH_FAULT, MEM_READ);
    end
    wait_valid(n, to, 1'b0);
    checks++;
    if (to || INSTRUCTION !== image[16] || FETCH_FAULT !== 1'b0) begin
      errors++;
      $display("FAIL align_forced_fetch: got timeout=%b ins=%h ff=%b expected ins=%h ff=0",
               to, INSTRUCTION, FETCH_FAULT, image[16]);
    end
`endif
  endtask

  // Random walk against an arithmetic PC model and the preloaded image.
  task automatic test_random();
    int n;
    bit to;
    bit hold_ok;
    int k;
    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic taken;
    RESET = 1'b1;
    for (int i = 0; i < WORDS; i++) load_word(i, $urandom);
    do_reset();
    RESET = 1'b0;
    exp_pc = 32'h0;
    for (int f = 0; f < 60; f++) begin
      wait_valid(n, to, 1'b1);
      checks++;
      if (to || n != FETCH_CYCLES || PC !== exp_pc || MEM_ADDRESS !== exp_pc[ADDR_W-1:0] ||
          INSTRUCTION !== image[exp_pc[ADDR_W-1:2]]) begin
        errors++;
        $display("FAIL rand_fetch%0d: got timeout=%b cycles=%0d pc=%h ins=%h expected cycles=%0d pc=%h ins=%h",
                 f, to, n, PC, INSTRUCTION, FETCH_CYCLES, exp_pc, image[exp_pc[ADDR_W-1:2]]);
      end
      k = $urandom_range(0, 3);
      hold_ok = 1'b1;
      for (int s = 0; s < k; s++) begin
        STALL         = 1'b1;
        BRANCH_TAKEN  = 1'($urandom_range(0, 1));
        BRANCH_TARGET = $urandom;
        step();
        if (PC !== exp_pc || INS_VALID !== 1'b1 || MEM_READ !== 1'b0 ||
            INSTRUCTION !== image[exp_pc[ADDR_W-1:2]]) hold_ok = 1'b0;
      end
      checks++;
      if (!hold_ok) begin
        errors++;
        $display("FAIL rand_stall%0d: got pc=%h v=%b rd=%b expected pc=%h v=1 rd=0",
                 f, PC, INS_VALID, MEM_READ, exp_pc);
      end
      taken = 1'($urandom_range(0, 1));
      tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
`ifdef ALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      STALL         = 1'b0;
      BRANCH_TAKEN  = taken;
      BRANCH_TARGET = tgt;
      exp_pc = taken ? {tgt[31:2], 2'b00} : exp_pc + 32'd4;
    end
    STALL = 1'b0;
    BRANCH_TAKEN = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
    load_en = 1'b0; load_addr = '0; load_data = 32'h0;
    for (int i = 0; i < WORDS; i++) load_word(i, $urandom);
    test_reset();
    test_first_fetch();
    test_sequence();
    test_stall();
    test_branch();
    test_reset_mid_wait();
    test_alignment();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Supplies the 32-bit INSTRUCTION word to the cpu; the cpu consumes it and this block produces it.
- Owns the program counter and fetches words from a multi-cycle instruction memory over a MEM_READ/MEM_BUSYWAIT handshake.
- Presents one instruction at a time with INS_VALID.
- Advances PC sequentially or to a branch target when the cpu releases the current instruction.

Parameters:
- ADDR_W, 10, instruction-memory byte-address width (1 KiB).
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- STALL  in  1  cpu cannot accept a new instruction; hold the current one.
- BRANCH_TAKEN  in  1  next PC is BRANCH_TARGET; sampled only when an instruction is released.
- BRANCH_TARGET  in  32  byte address of the branch destination.
- MEM_READDATA  in  32  instruction word from memory; valid when MEM_READ=1 and MEM_BUSYWAIT=0.
- MEM_BUSYWAIT  in  1  memory has not finished the read.
- MEM_READ  out  1  read request; held high until data is accepted.
- MEM_ADDRESS  out  ADDR_W  PC[ADDR_W-1:0].
- PC  out  32  address of the instruction being fetched or presented.
- INSTRUCTION  out  32  registered instruction word to the cpu.
- INS_VALID  out  1  INSTRUCTION is valid for the cpu.
- BUSYWAIT  out  1  equals ~INS_VALID; the cpu must freeze while this is high.
- FETCH_FAULT  out  1  misaligned branch target (see Optional Feature).

Behaviour:
- Reset (RESET=1 at any edge, including mid-fetch):
  - PC=RESET_PC, INSTRUCTION=0, INS_VALID=0, MEM_READ=0, FETCH_FAULT=0, state IDLE.
  - Any outstanding read is abandoned.
- States: IDLE, WAIT, ISSUE, FAULT.
- IDLE: at the next edge with RESET=0 -> MEM_READ<=1, go WAIT.
- WAIT:
  - MEM_READ held at 1; MEM_ADDRESS=PC[ADDR_W-1:0], stable throughout.
  - At the edge where MEM_BUSYWAIT=0: INSTRUCTION<=MEM_READDATA, INS_VALID<=1, MEM_READ<=0, go ISSUE.
- ISSUE:
  - If STALL=1: hold everything.
  - If STALL=0: PC <= BRANCH_TAKEN ? BRANCH_TARGET : PC+4; INS_VALID<=0; MEM_READ<=1; go WAIT.
- Memory contract (honoured by instr_mem_model):
  - MEM_BUSYWAIT = MEM_READ & (cnt != LAT).
  - cnt <= (MEM_READ & cnt!=LAT) ? cnt+1 : 0.
- Latency: with memory latency LAT, INS_VALID rises at the (LAT+2)th edge after leaving IDLE/ISSUE. Unstalled throughput is one instruction per LAT+2 cycles.
- Arithmetic and addressing:
  - PC+4 wraps modulo 2^32.
  - MEM_ADDRESS truncates the PC, so fetches alias modulo 2^ADDR_W.
  - Memory word index = address[ADDR_W-1:2].
- Simultaneous events:
  - RESET overrides everything.
  - BRANCH_TAKEN is ignored while in WAIT or while STALL=1.
  - A STALL arriving in WAIT has no effect until ISSUE.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: a release from ISSUE with BRANCH_TAKEN=1 and BRANCH_TARGET[1:0]!=0 goes to FAULT instead of WAIT.
  - In FAULT: FETCH_FAULT=1, INS_VALID=0, MEM_READ=0, PC=BRANCH_TARGET.
  - FAULT is left only by RESET.
- Undefined: the branch target has bits [1:0] forced to 00 and FETCH_FAULT is tied to 0. The port exists in both builds.

Decomposition:
- Package fetch_pkg:
  - state enum (IDLE, WAIT, ISSUE, FAULT);
  - WORD_BYTES=4;
  - default RESET_PC;
  - INS_W=32.
- Sub-module instr_mem_model:
  - behavioural word memory with parameter LAT (default 4);
  - implements the memory contract above;
  - preloadable;
  - used by the bench and the cpu-level testbench.

Test Plan:
1. Preload word0=32'hFF030201, LAT=4, STALL=0, release RESET -> MEM_READ rises at edge 1; INS_VALID=1 with INSTRUCTION=FF030201 and PC=0 at edge 6; PC=4 at edge 7.
2. Words 0..3 = 0x11,0x22,0x33,0x44, no stall -> INSTRUCTION sequence 0x11..0x44 at PCs 0,4,8,12, each valid for exactly one cycle, spaced 6 cycles apart.
3. STALL=1 for 10 cycles during ISSUE at PC=8 -> INSTRUCTION and PC constant, MEM_READ=0; next fetch at PC=12 begins the edge after STALL falls.
4. BRANCH_TAKEN=1, BRANCH_TARGET=0x40 on release at PC=4 -> next MEM_ADDRESS=0x40; BRANCH_TAKEN pulsed while in WAIT -> ignored.
5. RESET asserted 2 cycles into WAIT at PC=0x40 -> next edge PC=0, MEM_READ=0, INS_VALID=0; restart fetches word0 normally.
6. ALIGN_CHECK_EN defined, BRANCH_TARGET=0x42 taken -> FETCH_FAULT=1, MEM_READ stays 0. Undefined -> next MEM_ADDRESS=0x40, FETCH_FAULT=0.
